// File: rtl/multicore_pkg.sv
// Shared constants and types for cores that share one data memory.
// Arbiter state encoding and the pointer-wrap helper live here.
package multicore_pkg;

   localparam int CORES         = 4;
   localparam int MEM_PAGE_SIZE = 256;

   typedef enum logic [1:0] {
      ARB,
      MEM,
      RESP
   } arb_state_t;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Round-robin find-first-set: searches req from ptr upward, wrapping to 0.
// Purely combinational; emits one-hot grant, winner index and any-request flag.
module rr_picker
   import multicore_pkg::*;
#(
   parameter int N  = CORES,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   logic [IW-1:0] cand;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      cand  = '0;
      for (int k = 0; k < N; k++) begin
         cand = IW'((int'(ptr_i) + k) % N);
         if (!any_o && req_i[cand]) begin
            any_o       = 1'b1;
            idx_o       = cand;
            gnt_o[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NUM_CORES cores.
// Writes: ARB->MEM (2 cycles); reads: ARB->MEM->RESP (3 cycles); all outputs registered.
module mem_arbiter
   import multicore_pkg::*;
#(
   parameter int NUM_CORES = CORES,
   parameter int ADDR_W    = $clog2(MEM_PAGE_SIZE),
   parameter int DATA_W    = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_CORES-1:0]        req,
   input  logic [NUM_CORES-1:0]        we,
   input  logic [NUM_CORES*ADDR_W-1:0] addr,
   input  logic [NUM_CORES*DATA_W-1:0] wdata,
   output logic [NUM_CORES-1:0]        gnt,
   output logic [NUM_CORES-1:0]        rvalid,
   output logic [DATA_W-1:0]           rdata,
   output logic                        mem_en,
   output logic                        mem_we,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   input  logic [DATA_W-1:0]           mem_rdata,
   output logic                        busy,
   output logic [15:0]                 access_count
);

   localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   arb_state_t           state_q;
   logic [IW-1:0]        ptr_q, ptr_d, win_q, pick_idx;
   logic [NUM_CORES-1:0] pick_gnt, win_oh_q, gnt_q, rvalid_q;
   logic                 pick_any;
   logic [DATA_W-1:0]    rdata_q, mem_wdata_q;
   logic                 mem_en_q, mem_we_q, busy_q;
   logic [ADDR_W-1:0]    mem_addr_q;
   logic [15:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]    addr_a  [NUM_CORES];
   logic [DATA_W-1:0]    wdata_a [NUM_CORES];

   for (genvar i = 0; i < NUM_CORES; i++) begin : g_unpack
      assign addr_a[i]  = addr[i*ADDR_W +: ADDR_W];
      assign wdata_a[i] = wdata[i*DATA_W +: DATA_W];
   end

   rr_picker #(
      .N  (NUM_CORES),
      .IW (IW)
   ) u_picker (
      .req_i (req),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   assign ptr_d = IW'(wrap_inc(int'(win_q), NUM_CORES));
   assign cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

   // The mem_* registers double as the latched request of the winning core.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ARB;
         ptr_q       <= '0;
         win_q       <= '0;
         win_oh_q    <= '0;
         gnt_q       <= '0;
         rvalid_q    <= '0;
         rdata_q     <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         gnt_q    <= '0;
         rvalid_q <= '0;
         mem_en_q <= 1'b0;
         mem_we_q <= 1'b0;
         case (state_q)
            ARB: begin
               if (pick_any) begin
                  win_q       <= pick_idx;
                  win_oh_q    <= pick_gnt;
                  gnt_q       <= pick_gnt;
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= we[pick_idx];
                  mem_addr_q  <= addr_a[pick_idx];
                  mem_wdata_q <= wdata_a[pick_idx];
                  busy_q      <= 1'b1;
                  state_q     <= MEM;
               end
            end
            MEM: begin
               if (mem_we_q) begin
                  ptr_q   <= ptr_d;
                  cnt_q   <= cnt_d;
                  busy_q  <= 1'b0;
                  state_q <= ARB;
               end else begin
                  state_q <= RESP;
               end
            end
            RESP: begin
               rdata_q  <= mem_rdata;
               rvalid_q <= win_oh_q;
               ptr_q    <= ptr_d;
               cnt_q    <= cnt_d;
               busy_q   <= 1'b0;
               state_q  <= ARB;
            end
            default: state_q <= ARB;
         endcase
      end
   end

   assign gnt          = gnt_q;
   assign rvalid       = rvalid_q;
   assign rdata        = rdata_q;
   assign mem_en       = mem_en_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign busy         = busy_q;
   assign access_count = cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a simple synchronous RAM beside it.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req, we;
   logic [31:0] addr, wdata;
   logic [3:0]  gnt, rvalid;
   logic [7:0]  rdata;
   logic        mem_en, mem_we;
   logic [7:0]  mem_addr, mem_wdata, mem_rdata;
   logic        busy;
   logic [15:0] access_count;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [256];
   logic [7:0] exp_rd [4] = '{8'h4A, 8'h4B, 8'h48, 8'h49};

   always #5 clk = ~clk;

   mem_arbiter #(.NUM_CORES(4), .ADDR_W(8), .DATA_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .we           (we),
      .addr         (addr),
      .wdata        (wdata),
      .gnt          (gnt),
      .rvalid       (rvalid),
      .rdata        (rdata),
      .mem_en       (mem_en),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .busy         (busy),
      .access_count (access_count)
   );

   // RAM content after reset is addr ^ 8'h5A.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
         mem_rdata <= '0;
      end else if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_core(input int c, input logic w, input logic [7:0] a, input logic [7:0] d);
      we[c]             = w;
      addr[c*8 +: 8]    = a;
      wdata[c*8 +: 8]   = d;
   endtask

   initial begin
      reset = 1'b1;
      req   = '0;
      we    = '0;
      addr  = '0;
      wdata = '0;
      repeat (3) tick();
      check("reset_outputs", {gnt, rvalid, mem_en, mem_we, busy, rdata, mem_addr, mem_wdata, access_count}, 0);
      reset = 1'b0;

      // Idle
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_quiet", {mem_en, busy, gnt, rvalid}, 0);
      end
      check("idle_count", access_count, 0);

      // Core 2 write then read back
      set_core(2, 1'b1, 8'h40, 8'hA5);
      req = 4'b0100;
      tick();
      check("wr_gnt", gnt, 4'b0100);
      check("wr_en_we", {mem_en, mem_we}, 2'b11);
      check("wr_addr", mem_addr, 8'h40);
      check("wr_data", mem_wdata, 8'hA5);
      check("wr_busy", busy, 1);
      req = '0;
      tick();
      check("wr_done", {gnt, mem_en, busy}, 0);
      check("wr_count", access_count, 1);
      set_core(2, 1'b0, 8'h40, 8'h00);
      req = 4'b0100;
      tick();
      check("rd_gnt", gnt, 4'b0100);
      check("rd_en_we", {mem_en, mem_we}, 2'b10);
      req = '0;
      tick();
      check("rd_resp_state", {rvalid, gnt, mem_en, busy}, 1);
      tick();
      check("rd_rvalid", rvalid, 4'b0100);
      check("rd_data", rdata, 8'hA5);
      check("rd_count", access_count, 2);
      tick();
      check("rd_rvalid_pulse", rvalid, 0);
      check("rd_hold", rdata, 8'hA5);

      // ptr is 3: cores 0 and 3 together wrap 3 -> 0
      set_core(0, 1'b1, 8'h50, 8'h11);
      set_core(3, 1'b1, 8'h53, 8'h33);
      req = 4'b1001;
      tick();
      check("wrap_first", gnt, 4'b1000);
      check("wrap_first_addr", mem_addr, 8'h53);
      req = 4'b0001;
      tick();
      check("wrap_gap", gnt, 0);
      tick();
      check("wrap_second", gnt, 4'b0001);
      check("wrap_second_addr", mem_addr, 8'h50);
      req = '0;
      tick();
      check("wrap_count", access_count, 4);

      // All cores reading continuously from reset
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      for (int c = 0; c < 4; c++) set_core(c, 1'b0, 8'(8'h10 + c), 8'h00);
      req = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("rr_gnt", gnt, 64'(1 << (k % 4)));
         check("rr_addr", mem_addr, 64'(8'h10 + (k % 4)));
         tick();
         tick();
         check("rr_rvalid", rvalid, 64'(1 << (k % 4)));
         check("rr_data", rdata, exp_rd[k % 4]);
      end
      req = '0;
      tick();
      check("rr_count", access_count, 8);

      // Reset during RESP of a core 1 read; ptr must return to 0
      set_core(2, 1'b1, 8'h60, 8'h77);
      req = 4'b0100;
      tick();
      check("rst_pre_gnt", gnt, 4'b0100);
      req = '0;
      tick();
      set_core(1, 1'b0, 8'h11, 8'h00);
      req = 4'b0010;
      tick();
      check("rst_rd_gnt", gnt, 4'b0010);
      req = '0;
      tick();
      check("rst_in_resp", busy, 1);
      reset = 1'b1;
      tick();
      check("rst_clear", {gnt, rvalid, mem_en, mem_we, busy, rdata, mem_addr, mem_wdata, access_count}, 0);
      reset = 1'b0;
      tick();
      check("rst_no_rvalid", {rvalid, mem_en}, 0);
      set_core(0, 1'b1, 8'h70, 8'h01);
      set_core(3, 1'b1, 8'h73, 8'h03);
      req = 4'b1001;
      tick();
      check("rst_ptr0", gnt, 4'b0001);
      req = 4'b1000;
      tick();
      tick();
      check("rst_next", gnt, 4'b1000);
      req = '0;
      tick();
      check("rst_count", access_count, 2);

      // Preload the counter near saturation, then keep writing from core 0
      force dut.cnt_q = 16'hFFFC;
      tick();
      release dut.cnt_q;
      check("sat_preload", access_count, 16'hFFFC);
      set_core(0, 1'b1, 8'h80, 8'hEE);
      req = 4'b0001;
      for (int k = 0; k < 6; k++) begin
         tick();
         check("sat_gnt", gnt, 4'b0001);
         tick();
         check("sat_count", access_count, (k >= 2) ? 64'hFFFF : 64'(16'hFFFD + k));
      end
      req = '0;
      tick();
      check("sat_idle", {gnt, mem_en, busy}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
